// File: rtl/fifo_wr_arb.sv
// fifo_wr_arb: round-robin burst arbiter sharing one FIFO push port
// among NUM_REQ valid/ready requesters, zero-latency pass-through.
module fifo_wr_arb #(
  parameter int NUM_REQ    = 4,
  parameter int DATA_WIDTH = 32,
  parameter int MAX_BURST  = 4,
  parameter int ID_WIDTH   = $clog2(NUM_REQ),
  parameter int BCNT_WIDTH = $clog2(MAX_BURST + 1)
) (
  input  logic                          clk_i,
  input  logic                          rst_n_i,
  input  logic                          flush_i,
  input  logic [NUM_REQ-1:0]            req_valid_i,
  input  logic [NUM_REQ*DATA_WIDTH-1:0] req_dat_i,
  output logic [NUM_REQ-1:0]            req_ready_o,
  input  logic                          fifo_full_i,
  output logic                          fifo_push_o,
  output logic [DATA_WIDTH-1:0]         fifo_dat_o,
  output logic                          fifo_flush_o,
  output logic [ID_WIDTH-1:0]           gnt_id_o,
  output logic                          busy_o
);

  typedef enum logic {IDLE, HOLD} state_e;

  state_e                state_q, state_d;
  logic [ID_WIDTH-1:0]   owner_q, owner_d;
  logic [ID_WIDTH-1:0]   rr_q, rr_d;
  logic [BCNT_WIDTH-1:0] cnt_q, cnt_d, cnt_nxt;
  logic [ID_WIDTH-1:0]   start, scan, sel;
  logic                  own_vld, any_sel, xfer;

  function automatic logic [ID_WIDTH-1:0] inc_id(
    input logic [ID_WIDTH-1:0] v
  );
    if (v == ID_WIDTH'(NUM_REQ - 1)) return '0;
    return v + 1'b1;
  endfunction

  assign own_vld = req_valid_i[owner_q];

  // Downward scan so the candidate closest to start wins.
  always_comb begin
    start   = (state_q == HOLD) ? inc_id(owner_q) : rr_q;
    scan    = start;
    sel     = owner_q;
    any_sel = 1'b0;
    if (state_q == HOLD && own_vld) begin
      any_sel = 1'b1;
    end else begin
      for (int i = NUM_REQ - 1; i >= 0; i--) begin
        scan = ID_WIDTH'((int'(start) + i) % NUM_REQ);
        if (req_valid_i[scan]) begin
          sel     = scan;
          any_sel = 1'b1;
        end
      end
    end
    any_sel = any_sel & rst_n_i;
  end

  assign xfer         = any_sel & ~fifo_full_i & ~flush_i;
  assign fifo_push_o  = xfer;
  assign fifo_flush_o = flush_i & rst_n_i;
  assign gnt_id_o     = any_sel ? sel : owner_q;
  assign busy_o       = (state_q == HOLD);

  always_comb begin
    req_ready_o = '0;
    fifo_dat_o  = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      if (any_sel && sel == ID_WIDTH'(k)) begin
        req_ready_o[k] = xfer;
        fifo_dat_o     = req_dat_i[k*DATA_WIDTH +: DATA_WIDTH];
      end
    end
  end

  always_comb begin
    state_d = state_q;
    owner_d = owner_q;
    rr_d    = rr_q;
    cnt_d   = cnt_q;
    cnt_nxt = (state_q == IDLE || sel != owner_q)
            ? BCNT_WIDTH'(1) : cnt_q + 1'b1;
    if (flush_i) begin
      state_d = IDLE;
      owner_d = '0;
      rr_d    = '0;
      cnt_d   = '0;
    end else if (!fifo_full_i) begin
      if (state_q == HOLD && !own_vld) begin
        rr_d    = inc_id(owner_q);
        state_d = IDLE;
        cnt_d   = '0;
      end
      if (xfer) begin
        if (cnt_nxt == BCNT_WIDTH'(MAX_BURST)) begin
          state_d = IDLE;
          cnt_d   = '0;
          rr_d    = inc_id(sel);
        end else begin
          state_d = HOLD;
          owner_d = sel;
          cnt_d   = cnt_nxt;
        end
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_q <= IDLE;
      owner_q <= '0;
      rr_q    <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      owner_q <= owner_d;
      rr_q    <= rr_d;
      cnt_q   <= cnt_d;
    end
  end

`ifndef SYNTHESIS
  always @(posedge clk_i) begin
    if (rst_n_i) begin
      assert ($onehot0(req_ready_o));
      assert (!(fifo_push_o && fifo_full_i));
      assert (!fifo_push_o || req_valid_i[gnt_id_o]);
      assert (cnt_q < BCNT_WIDTH'(MAX_BURST));
    end
  end
`endif

endmodule

// File: tb/tb_fifo_wr_arb.sv
// Bench for fifo_wr_arb: directed table rows, corner sequences and
// random traffic against a cycle model, MAX_BURST=4 and =2 copies.
module tb_fifo_wr_arb;
  localparam int NR = 4;
  localparam int DW = 32;
  localparam int ID = 2;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic flush = 1'b0;
  logic full = 1'b0;
  logic [NR-1:0] vld = '0;
  logic [NR*DW-1:0] dat = '0;

  logic [NR-1:0] rdy_o [2];
  logic          push_o [2];
  logic [DW-1:0] fdat_o [2];
  logic          fflush_o [2];
  logic [ID-1:0] gnt_o [2];
  logic          busy_o [2];

  always #5 clk = ~clk;

  fifo_wr_arb #(.NUM_REQ(NR), .DATA_WIDTH(DW), .MAX_BURST(4)) u_mb4 (
    .clk_i(clk), .rst_n_i(rst_n), .flush_i(flush),
    .req_valid_i(vld), .req_dat_i(dat), .req_ready_o(rdy_o[0]),
    .fifo_full_i(full), .fifo_push_o(push_o[0]),
    .fifo_dat_o(fdat_o[0]), .fifo_flush_o(fflush_o[0]),
    .gnt_id_o(gnt_o[0]), .busy_o(busy_o[0])
  );

  fifo_wr_arb #(.NUM_REQ(NR), .DATA_WIDTH(DW), .MAX_BURST(2)) u_mb2 (
    .clk_i(clk), .rst_n_i(rst_n), .flush_i(flush),
    .req_valid_i(vld), .req_dat_i(dat), .req_ready_o(rdy_o[1]),
    .fifo_full_i(full), .fifo_push_o(push_o[1]),
    .fifo_dat_o(fdat_o[1]), .fifo_flush_o(fflush_o[1]),
    .gnt_id_o(gnt_o[1]), .busy_o(busy_o[1])
  );

  int passed = 0;
  int total = 0;
  int mb [2] = '{4, 2};
  bit m_hold [2];
  int m_owner [2];
  int m_rr [2];
  int m_cnt [2];

  typedef struct {
    bit            rst;
    int            inst;
    logic [NR-1:0] v;
    bit            pu;
    int            g;
    logic [NR-1:0] r;
    bit            b;
  } row_t;
  row_t tbl [$];

  task automatic chk(input string nm, input logic [63:0] act,
                     input logic [63:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %0h, want %0h", nm, act, exp);
  endtask

  function automatic int pick(input int j);
    int s;
    if (m_hold[j] && vld[m_owner[j]]) return m_owner[j];
    s = m_hold[j] ? (m_owner[j] + 1) % NR : m_rr[j];
    for (int k = 0; k < NR; k++)
      if (vld[(s + k) % NR]) return (s + k) % NR;
    return -1;
  endfunction

  task automatic m_reset();
    for (int j = 0; j < 2; j++) begin
      m_hold[j] = 1'b0;
      m_owner[j] = 0;
      m_rr[j] = 0;
      m_cnt[j] = 0;
    end
  endtask

  task automatic m_step();
    for (int j = 0; j < 2; j++) begin
      int s;
      int n;
      s = pick(j);
      n = (!m_hold[j] || s != m_owner[j]) ? 1 : m_cnt[j] + 1;
      if (!rst_n) continue;
      if (flush) begin
        m_hold[j] = 1'b0;
        m_owner[j] = 0;
        m_rr[j] = 0;
        m_cnt[j] = 0;
        continue;
      end
      if (full) continue;
      if (m_hold[j] && !vld[m_owner[j]]) begin
        m_rr[j] = (m_owner[j] + 1) % NR;
        m_hold[j] = 1'b0;
        m_cnt[j] = 0;
      end
      if (s >= 0) begin
        if (n == mb[j]) begin
          m_hold[j] = 1'b0;
          m_cnt[j] = 0;
          m_rr[j] = (s + 1) % NR;
        end else begin
          m_hold[j] = 1'b1;
          m_owner[j] = s;
          m_cnt[j] = n;
        end
      end
    end
  endtask

  task automatic m_check();
    for (int j = 0; j < 2; j++) begin
      int s;
      bit any;
      bit psh;
      logic [NR-1:0] er;
      logic [DW-1:0] ed;
      int eg;
      s = pick(j);
      any = rst_n && s >= 0;
      psh = any && !full && !flush;
      er = '0;
      ed = '0;
      eg = m_owner[j];
      if (any) begin
        ed = dat[s*DW +: DW];
        eg = s;
        if (psh) er[s] = 1'b1;
      end
      chk($sformatf("m%0d push", j), 64'(push_o[j]), 64'(psh));
      chk($sformatf("m%0d ready", j), 64'(rdy_o[j]), 64'(er));
      chk($sformatf("m%0d data", j), 64'(fdat_o[j]), 64'(ed));
      chk($sformatf("m%0d gnt", j), 64'(gnt_o[j]), 64'(eg));
      chk($sformatf("m%0d busy", j), 64'(busy_o[j]), 64'(m_hold[j]));
      chk($sformatf("m%0d flush", j), 64'(fflush_o[j]),
          64'(flush && rst_n));
    end
  endtask

  task automatic apply(input logic [NR-1:0] v, input bit f,
                       input bit fl, input bit r = 1'b1);
    @(negedge clk);
    vld = v;
    full = f;
    flush = fl;
    rst_n = r;
    for (int k = 0; k < NR; k++) dat[k*DW +: DW] = $urandom;
    if (!r) m_reset();
    #1;
    m_check();
  endtask

  task automatic commit();
    @(posedge clk);
    m_step();
  endtask

  task automatic do_reset();
    apply('0, 1'b0, 1'b0, 1'b0);
    commit();
    apply('0, 1'b0, 1'b0, 1'b0);
    commit();
  endtask

  initial begin
    int bs [6] = '{0, 1, 1, 1, 0, 1};
    int gs [10] = '{0, 0, 1, 1, 2, 2, 3, 3, 0, 0};
    logic [NR-1:0] one;
    m_reset();

    for (int i = 0; i < 6; i++)
      tbl.push_back('{i == 0, 0, 4'b0100, 1'b1, 2, 4'b0100, bs[i] != 0});
    tbl.push_back('{1'b0, 0, 4'b0000, 1'b0, 2, 4'b0000, 1'b1});
    tbl.push_back('{1'b0, 0, 4'b0000, 1'b0, 2, 4'b0000, 1'b0});
    for (int i = 0; i < 10; i++) begin
      one = '0;
      one[gs[i]] = 1'b1;
      tbl.push_back('{i == 0, 1, 4'b1111, 1'b1, gs[i], one, i % 2 == 1});
    end

    foreach (tbl[i]) begin
      if (tbl[i].rst) do_reset();
      apply(tbl[i].v, 1'b0, 1'b0);
      chk($sformatf("row%0d push", i), 64'(push_o[tbl[i].inst]),
          64'(tbl[i].pu));
      chk($sformatf("row%0d gnt", i), 64'(gnt_o[tbl[i].inst]),
          64'(tbl[i].g));
      chk($sformatf("row%0d ready", i), 64'(rdy_o[tbl[i].inst]),
          64'(tbl[i].r));
      chk($sformatf("row%0d busy", i), 64'(busy_o[tbl[i].inst]),
          64'(tbl[i].b));
      if (tbl[i].pu)
        chk($sformatf("row%0d data", i), 64'(fdat_o[tbl[i].inst]),
            64'(dat[tbl[i].g*DW +: DW]));
      commit();
    end

    // FIFO full mid-burst
    do_reset();
    apply(4'b0010, 1'b0, 1'b0);
    chk("full beat1 gnt", 64'(gnt_o[0]), 64'd1);
    commit();
    apply(4'b1011, 1'b0, 1'b0);
    chk("full beat2 gnt", 64'(gnt_o[0]), 64'd1);
    commit();
    repeat (3) begin
      apply(4'b1011, 1'b1, 1'b0);
      chk("stall push", 64'(push_o[0]), 64'd0);
      chk("stall ready", 64'(rdy_o[0]), 64'd0);
      commit();
    end
    repeat (2) begin
      apply(4'b1011, 1'b0, 1'b0);
      chk("resume gnt", 64'(gnt_o[0]), 64'd1);
      chk("resume push", 64'(push_o[0]), 64'd1);
      commit();
    end
    apply(4'b1011, 1'b0, 1'b0);
    chk("after release gnt", 64'(gnt_o[0]), 64'd3);
    commit();

    // Owner drop
    do_reset();
    apply(4'b0001, 1'b0, 1'b0);
    commit();
    apply(4'b0100, 1'b0, 1'b0);
    chk("drop gnt", 64'(gnt_o[0]), 64'd2);
    chk("drop push", 64'(push_o[0]), 64'd1);
    commit();
    repeat (3) begin
      apply(4'b0100, 1'b0, 1'b0);
      commit();
    end
    apply(4'b1111, 1'b0, 1'b0);
    chk("drop busy", 64'(busy_o[0]), 64'd0);
    chk("drop rr gnt", 64'(gnt_o[0]), 64'd3);
    commit();

    // Flush during HOLD, with rr already moved off 0
    do_reset();
    repeat (4) begin
      apply(4'b0001, 1'b0, 1'b0);
      commit();
    end
    repeat (2) begin
      apply(4'b0010, 1'b0, 1'b0);
      commit();
    end
    apply(4'b0010, 1'b0, 1'b1);
    chk("flush out", 64'(fflush_o[0]), 64'd1);
    chk("flush push", 64'(push_o[0]), 64'd0);
    commit();
    apply(4'b1111, 1'b0, 1'b0);
    chk("post flush busy", 64'(busy_o[0]), 64'd0);
    chk("post flush gnt", 64'(gnt_o[0]), 64'd0);
    commit();

    // Async reset mid-burst
    do_reset();
    repeat (2) begin
      apply(4'b1000, 1'b0, 1'b0);
      commit();
    end
    repeat (2) begin
      apply(4'b1111, 1'b0, 1'b1, 1'b0);
      chk("rst push", 64'(push_o[0]), 64'd0);
      chk("rst ready", 64'(rdy_o[0]), 64'd0);
      chk("rst data", 64'(fdat_o[0]), 64'd0);
      chk("rst gnt", 64'(gnt_o[0]), 64'd0);
      chk("rst busy", 64'(busy_o[0]), 64'd0);
      chk("rst flush", 64'(fflush_o[0]), 64'd0);
      commit();
    end
    apply(4'b1111, 1'b0, 1'b0);
    chk("post rst gnt", 64'(gnt_o[0]), 64'd0);
    chk("post rst push", 64'(push_o[0]), 64'd1);
    commit();

    repeat (400) begin
      apply(NR'($urandom), $urandom_range(3) == 0,
            $urandom_range(19) == 0, $urandom_range(49) != 0);
      commit();
    end

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
